bcd_tick_counter: RTL and testbench

- Parametrised multi-digit BCD counter; generalised successor of the board-level BCD counter.
- Runs on the single system clock and advances on an internal prescaler tick, replacing the divided "slow clock".
- Adds up/down counting, parallel load, synchronous clear, wrap or saturate at the limits, terminal-count and overflow flags, and leading-zero blanking masks.
- Feeds the BCD-to-seven-segment decoder on HEX0..HEX(DIGITS-1).

---
 rtl/bcd_tick_counter.sv | 203 ++++++++++++++++++++
 tb/tb_bcd_tick_counter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: multi-digit BCD up/down counter advanced by an internal prescaler tick.
//
// Parameters:
//   DIGITS   - number of BCD digits (count width 4*DIGITS)
//   DIV      - prescaler period in clocks (>= 1)
//   DIV_W    - prescaler counter width (2**DIV_W >= DIV)
//   SATURATE - 0: wrap at the limits, 1: hold at the limits
//
// Ports:
//   clk, rst_n       - system clock, asynchronous active-low reset
//   en               - gates prescaler and counter
//   up               - direction (1 = increment), sampled on the tick cycle
//   clear, load      - synchronous clear / parallel load (clear wins)
//   load_val         - BCD load value, digits >9 are clamped to 9
//   count            - live BCD count
//   disp             - registered display copy of count
//   tick             - one-clock prescaler pulse
//   tc               - one-clock pulse when a step hits a limit
//   overflow         - sticky limit flag
//   blank            - leading-zero blank mask derived from disp
//
// Optional feature (macro LAP_BCD_EN): adds input lap and output frozen. A rising edge on lap
// toggles frozen; while frozen, disp holds its captured value and count keeps running.

module bcd_tick_counter #(
    parameter int unsigned DIGITS   = 5,
    parameter int unsigned DIV      = 5000,
    parameter int unsigned DIV_W    = 13,
    parameter int unsigned SATURATE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
`ifdef LAP_BCD_EN
    input  logic                lap,
    output logic                frozen,
`endif
    output logic [4*DIGITS-1:0] count,
    output logic [4*DIGITS-1:0] disp,
    output logic                tick,
    output logic                tc,
    output logic                overflow,
    output logic [DIGITS-1:0]   blank
);

    localparam int unsigned W = 4 * DIGITS;
    localparam logic [DIV_W-1:0] PrescLast = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d;
    logic [W-1:0]     count_q, count_d;
    logic [W-1:0]     disp_q, disp_d;
    logic             tc_q, tc_d;
    logic             overflow_q, overflow_d;

    logic [W-1:0]     stepped;
    logic             at_limit;
    logic             carry;
    logic [3:0]       digit;
    logic [W-1:0]     load_clamped;
    logic             zero_above;

    // Ripple one step through all digits in a single cycle. A carry/borrow out of the top
    // digit means the count was at its limit; stepped then holds the wrapped value.
    always_comb begin
        stepped = count_q;
        carry   = 1'b1;
        digit   = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit = count_q[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (digit == 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = digit + 4'd1;
                        carry             = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = digit - 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
        at_limit = carry;
    end

    always_comb begin
        load_clamped = load_val;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    always_comb begin
        presc_d    = presc_q;
        tick_d     = 1'b0;
        count_d    = count_q;
        tc_d       = 1'b0;
        overflow_d = overflow_q;
        if (en) begin
            presc_d = (presc_q == PrescLast) ? '0 : presc_q + DIV_W'(1);
            tick_d  = (presc_q == PrescLast);
        end
        // Clear/load restart the prescaler, so any pending tick is dropped as well.
        if (clear) begin
            count_d    = '0;
            presc_d    = '0;
            tick_d     = 1'b0;
            overflow_d = 1'b0;
        end else if (load) begin
            count_d    = load_clamped;
            presc_d    = '0;
            tick_d     = 1'b0;
            overflow_d = 1'b0;
        end else if (tick_q) begin
            if (at_limit) begin
                tc_d       = 1'b1;
                overflow_d = 1'b1;
                count_d    = (SATURATE != 0) ? count_q : stepped;
            end else begin
                count_d = stepped;
            end
        end
    end

`ifdef LAP_BCD_EN
    logic lap_q;
    logic frozen_q, frozen_d;

    always_comb begin
        frozen_d = frozen_q;
        if (clear) begin
            frozen_d = 1'b0;
        end else if (lap && !lap_q) begin
            frozen_d = !frozen_q;
        end
        // On the freezing edge frozen_q is still 0, so disp captures the pre-step count.
        disp_d = frozen_q ? disp_q : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q    <= 1'b0;
            frozen_q <= 1'b0;
        end else begin
            lap_q    <= lap;
            frozen_q <= frozen_d;
        end
    end

    assign frozen = frozen_q;
`else
    always_comb begin
        disp_d = count_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            count_q    <= '0;
            disp_q     <= '0;
            tc_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            count_q    <= count_d;
            disp_q     <= disp_d;
            tc_q       <= tc_d;
            overflow_q <= overflow_d;
        end
    end

    // blank[i] is set when digit i and every digit above it are zero; digit 0 always shows.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_above = zero_above & (disp_q[4*i +: 4] == 4'd0);
            blank[i]   = zero_above;
        end
    end

    assign count    = count_q;
    assign disp     = disp_q;
    assign tick     = tick_q;
    assign tc       = tc_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
module tb_bcd_tick_counter;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DIV_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, up, clear, load, lap;
    logic [11:0] load_val;
    logic [19:0] load_val5;
    assign load_val5 = {8'h00, load_val};

    logic [11:0] count0, disp0, count1, disp1;
    logic [19:0] count5, disp5;
    logic        tick0, tick1, tick5, tc0, tc1, tc5, ovf0, ovf1, ovf5;
    logic        frozen0, frozen1, frozen5;
    logic [2:0]  blank0, blank1;
    logic [4:0]  blank5;

`ifndef LAP_BCD_EN
    assign frozen0 = 1'b0;
    assign frozen1 = 1'b0;
    assign frozen5 = 1'b0;
`endif

    bcd_tick_counter #(.DIGITS(3), .DIV(DIV), .DIV_W(DIV_W), .SATURATE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val),
`ifdef LAP_BCD_EN
        .lap(lap), .frozen(frozen0),
`endif
        .count(count0), .disp(disp0), .tick(tick0), .tc(tc0), .overflow(ovf0), .blank(blank0)
    );

    bcd_tick_counter #(.DIGITS(3), .DIV(DIV), .DIV_W(DIV_W), .SATURATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val),
`ifdef LAP_BCD_EN
        .lap(lap), .frozen(frozen1),
`endif
        .count(count1), .disp(disp1), .tick(tick1), .tc(tc1), .overflow(ovf1), .blank(blank1)
    );

    bcd_tick_counter #(.DIGITS(5), .DIV(DIV), .DIV_W(DIV_W), .SATURATE(0)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val5),
`ifdef LAP_BCD_EN
        .lap(lap), .frozen(frozen5),
`endif
        .count(count5), .disp(disp5), .tick(tick5), .tc(tc5), .overflow(ovf5), .blank(blank5)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counts are plain decimal integers, converted to BCD only for comparison.
    int m_val[3];
    int m_disp[3];
    bit m_tc[3];
    bit m_ovf[3];
    int m_presc;
    bit m_tick;
    bit m_frozen;
    bit m_lap_q;

    function automatic int nd_of(int k);
        return (k == 2) ? 5 : 3;
    endfunction

    function automatic bit sat_of(int k);
        return (k == 1);
    endfunction

    function automatic int pow10(int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [19:0] to_bcd(int v, int n);
        logic [19:0] r = '0;
        int t = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(logic [19:0] lv, int n);
        int v = 0;
        for (int i = 0; i < n; i++) begin
            int d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * pow10(i);
        end
        return v;
    endfunction

    function automatic logic [4:0] blank_of(int d, int n);
        logic [4:0] r = '0;
        for (int i = 1; i < n; i++) r[i] = ((d / pow10(i)) == 0);
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare_one(string tag, int k, logic [31:0] cnt, logic [31:0] dsp,
                               logic tk, logic tcv, logic ov, logic [31:0] bl, logic fr);
        int n = nd_of(k);
        check({tag, "_count"}, cnt, 32'(to_bcd(m_val[k], n)));
        check({tag, "_disp"}, dsp, 32'(to_bcd(m_disp[k], n)));
        check({tag, "_tick"}, 32'(tk), 32'(m_tick));
        check({tag, "_tc"}, 32'(tcv), 32'(m_tc[k]));
        check({tag, "_overflow"}, 32'(ov), 32'(m_ovf[k]));
        check({tag, "_blank"}, bl, 32'(blank_of(m_disp[k], n)));
`ifdef LAP_BCD_EN
        check({tag, "_frozen"}, 32'(fr), 32'(m_frozen));
`endif
    endtask

    task automatic compare_all();
        compare_one("d0", 0, 32'(count0), 32'(disp0), tick0, tc0, ovf0, 32'(blank0), frozen0);
        compare_one("d1", 1, 32'(count1), 32'(disp1), tick1, tc1, ovf1, 32'(blank1), frozen1);
        compare_one("d5", 2, 32'(count5), 32'(disp5), tick5, tc5, ovf5, 32'(blank5), frozen5);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_val[k] = 0; m_disp[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
        end
        m_presc = 0; m_tick = 0; m_frozen = 0; m_lap_q = 0;
    endtask

    // Advance DUTs and model by one clock, then compare every output.
    task automatic step_cycle();
        int nv[3], ndisp[3], np, mx;
        bit ntc[3], novf[3], ntk, nfr;
        for (int k = 0; k < 3; k++) begin
            mx = pow10(nd_of(k)) - 1;
            nv[k] = m_val[k]; ntc[k] = 0; novf[k] = m_ovf[k];
            if (clear) begin
                nv[k] = 0; novf[k] = 0;
            end else if (load) begin
                nv[k] = clamp_val(load_val5, nd_of(k)); novf[k] = 0;
            end else if (m_tick) begin
                if (up) begin
                    if (m_val[k] == mx) begin
                        ntc[k] = 1; novf[k] = 1; nv[k] = sat_of(k) ? mx : 0;
                    end else nv[k] = m_val[k] + 1;
                end else begin
                    if (m_val[k] == 0) begin
                        ntc[k] = 1; novf[k] = 1; nv[k] = sat_of(k) ? 0 : mx;
                    end else nv[k] = m_val[k] - 1;
                end
            end
`ifdef LAP_BCD_EN
            ndisp[k] = m_frozen ? m_disp[k] : m_val[k];
`else
            ndisp[k] = m_val[k];
`endif
        end
        np = m_presc; ntk = 0;
        if (en) begin
            ntk = (m_presc == DIV - 1);
            np  = ntk ? 0 : m_presc + 1;
        end
        if (clear || load) begin
            np = 0; ntk = 0;
        end
        nfr = m_frozen;
        if (clear) nfr = 0;
        else if (lap && !m_lap_q) nfr = !m_frozen;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            m_val[k] = nv[k]; m_disp[k] = ndisp[k]; m_tc[k] = ntc[k]; m_ovf[k] = novf[k];
        end
        m_presc = np; m_tick = ntk; m_frozen = nfr; m_lap_q = lap;
        compare_all();
    endtask

    typedef struct {
        logic [11:0] lv;
        logic [11:0] exp_count;
        logic [4:0]  exp_blank5;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int   ticks, tcs, n;
        bit   got;

        vecs[0] = '{12'hA3F, 12'h939, 5'b11000};
        vecs[1] = '{12'h007, 12'h007, 5'b11110};
        vecs[2] = '{12'h000, 12'h000, 5'b11110};
        vecs[3] = '{12'h070, 12'h070, 5'b11100};
        vecs[4] = '{12'hFFF, 12'h999, 5'b11000};
        vecs[5] = '{12'h0B0, 12'h090, 5'b11100};
        vecs[6] = '{12'h00C, 12'h009, 5'b11110};
        vecs[7] = '{12'h9A0, 12'h990, 5'b11000};

        rst_n = 0; en = 0; up = 1; clear = 0; load = 0; lap = 0; load_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_blank5", 32'(blank5), 32'h1E);
        rst_n = 1;

        // Free run from reset: ten ticks take 009 -> 010 in one step.
        en = 1; up = 1; ticks = 0;
        for (int i = 0; i < 41; i++) begin
            step_cycle();
            if (tick0) ticks++;
        end
        check("run_ticks", 32'(ticks), 32'd10);
        check("run_count_010", 32'(count0), 32'h010);

        // Up-wrap from 998.
        load = 1; load_val = 12'h998;
        step_cycle();
        load = 0; tcs = 0;
        for (int i = 0; i < 10; i++) begin
            step_cycle();
            if (tc0) tcs++;
        end
        check("wrap_tc_pulses", 32'(tcs), 32'd1);
        check("wrap_count", 32'(count0), 32'h000);
        check("wrap_overflow", 32'(ovf0), 32'd1);
        check("sat_hold_999", 32'(count1), 32'h999);

        // Down-saturate from 001.
        up = 0; load = 1; load_val = 12'h001;
        step_cycle();
        load = 0; tcs = 0;
        for (int i = 0; i < 13; i++) begin
            step_cycle();
            if (tc1) tcs++;
        end
        check("sat_tc_pulses", 32'(tcs), 32'd2);
        check("sat_count", 32'(count1), 32'h000);
        check("sat_overflow", 32'(ovf1), 32'd1);

        // Clear beats load; prescaler restarts.
        up = 1; clear = 1; load = 1; load_val = 12'h555;
        step_cycle();
        clear = 0; load = 0;
        check("clr_ld_count", 32'(count0), 32'h000);
        check("clr_ld_overflow", 32'(ovf1), 32'd0);
        n = 0; got = 0;
        while (!got && n < 20) begin
            step_cycle();
            n++;
            if (tick0) got = 1;
        end
        check("clr_ld_tick_gap", 32'(n), 32'd4);

        // Load clamping and blanking table.
        en = 0;
        repeat (2) step_cycle();
        for (int i = 0; i < 8; i++) begin
            load = 1; load_val = vecs[i].lv;
            step_cycle();
            load = 0;
            step_cycle();
            check("tbl_count", 32'(count0), 32'(vecs[i].exp_count));
            check("tbl_blank5", 32'(blank5), 32'(vecs[i].exp_blank5));
        end

`ifdef LAP_BCD_EN
        en = 1; up = 1; load = 1; load_val = 12'h012;
        step_cycle();
        load = 0; lap = 1;
        step_cycle();
        lap = 0;
        repeat (32) step_cycle();
        check("lap_count", 32'(count0), 32'h020);
        check("lap_disp", 32'(disp0), 32'h012);
        lap = 1;
        step_cycle();
        lap = 0;
        step_cycle();
        check("lap_unfrozen", 32'(frozen0), 32'd0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            up    = 1'($urandom_range(0, 1));
            clear = ($urandom_range(0, 59) == 0);
            load  = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 12'h999;
                1:       load_val = 12'h000;
                2:       load_val = 12'h998;
                default: load_val = 12'($urandom);
            endcase
`ifdef LAP_BCD_EN
            lap = ($urandom_range(0, 15) == 0);
`endif
            step_cycle();
        end

        // Asynchronous reset mid-count.
        clear = 0; load = 0; lap = 0; en = 1; up = 1;
        repeat (7) step_cycle();
        #2 rst_n = 0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1;
        repeat (10) step_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
